gf16_mult_seq: RTL and testbench
================================

GF16_MULT_SEQ -- requirements
Module: gf16_mult_seq

Interface
REQ-001 SHALL have parameter POLY, default 16'h002B, giving the low 16 coefficients of the field polynomial x^16+x^5+x^3+x+1 (x^16 term implicit).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  16  multiplicand, bit i = coefficient of x^i.
REQ-007 SHALL have port b  input  16  multiplier, same encoding.
REQ-008 SHALL have port out_valid  output  1  c holds a finished product.
REQ-009 SHALL have port out_ready  input  1  consumer takes c.
REQ-010 SHALL have port c  output  16  a*b mod field polynomial, GF(2) arithmetic.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DONE; only one state active at a time.
REQ-012 SHALL drive in_ready=1 only in IDLE; accept when in_valid && in_ready on a rising edge, capturing a and b and clearing the accumulator.
REQ-013 SHALL, in MUL, process one nibble of captured b per cycle, most significant first (b[15:12], b[11:8], b[7:4], b[3:0]), via a 2-bit step counter 0..3.
REQ-014 SHALL update each MUL cycle: t = (acc<<4) XOR clmul(a, nibble) (20 bits); acc <= t[15:0] XOR clmul(t[19:16], POLY), all additions XOR, no carries.
REQ-015 SHALL leave MUL for DONE on the edge where step 3 is applied; out_valid rises on the 4th edge after acceptance (latency 4 cycles).
REQ-016 SHALL in DONE hold out_valid=1 and c=acc stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-017 SHALL ignore in_valid, a and b outside IDLE; operand changes after acceptance do not affect the result.
REQ-018 SHALL drive c=0 whenever out_valid=0.
REQ-019 SHALL produce c=0 when either operand is 0; throughput is one product per 6 cycles with out_ready held high.

Reset
REQ-020 SHALL on rst_n=0, at any time including mid-MUL, enter IDLE with acc=0, step=0, out_valid=0, c=0, in_ready=1 after release; the in-flight operation is discarded.

Configuration
REQ-021 SHALL, when GF16_MULT_RAW_EN is defined, add output c_raw (31 bits, unreduced carryless a*b) computed in parallel as raw <= (raw<<4) XOR clmul(a, nibble), valid under out_valid, 0 otherwise and at reset.
REQ-022 SHALL, when GF16_MULT_RAW_EN is undefined, omit port c_raw and its register, with no other behavioural change.

Structure
REQ-023 SHALL place the state enum, POLY_DEFAULT=16'h002B, NIB_STEPS=4 and nibble width in shared package gf16_pkg.
REQ-024 SHALL instantiate one combinational sub-module clmul_16x4 (16-bit x 4-bit carryless product, 19-bit result) reused for both the partial product and the fold term.

Verification
REQ-025 SHALL check a=16'h0001, b=16'h1234 -> c=16'h1234, out_valid exactly 4 edges after acceptance.
REQ-026 SHALL check a=16'h8000, b=16'h0002 -> c=16'h002B; with GF16_MULT_RAW_EN, c_raw=31'h0001_0000.
REQ-027 SHALL check a=16'hFFFF, b=16'h0000 -> c=16'h0000; and a=16'h0100, b=16'h0100 -> c=16'h002B.
REQ-028 SHALL check backpressure: out_ready low 10 cycles -> c, out_valid stable, in_ready=0, new in_valid ignored; product taken on first out_ready cycle.
REQ-029 SHALL check reset asserted at step 2 of MUL -> outputs zero immediately, IDLE after release, next operation correct.
REQ-030 SHALL check 1000 random operand pairs with random out_ready against a bitwise GF(2^16) reference model.

Source files
------------

// File: rtl/gf16_pkg.sv
// Shared definitions for the sequential GF(2^16) multiplier:
// FSM state encoding, default field polynomial and nibble-serial step geometry.
package gf16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Low 16 coefficients of x^16 + x^5 + x^3 + x + 1 (x^16 term implicit).
    localparam logic [15:0] POLY_DEFAULT = 16'h002B;

    // Multiplier is consumed one nibble per cycle, MSB nibble first.
    localparam int NIB_W     = 4;
    localparam int NIB_STEPS = 4;

endpackage : gf16_pkg

// File: rtl/clmul_16x4.sv
// Combinational carryless (GF(2) polynomial) product of a 16-bit operand and
// a 4-bit operand; the result is 19 bits wide (degree <= 15 + 3).
module clmul_16x4
    import gf16_pkg::*;
(
    input  logic [15:0]      a_i,
    input  logic [NIB_W-1:0] b_i,
    output logic [18:0]      p_o
);

    logic [18:0] pp [NIB_W];

    // One shifted copy of a_i per set bit of b_i.
    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_pp
            assign pp[gi] = b_i[gi] ? (19'(a_i) << gi) : 19'd0;
        end
    endgenerate

    // Addition in GF(2) is XOR, so the partial products simply XOR together.
    assign p_o = pp[0] ^ pp[1] ^ pp[2] ^ pp[3];

endmodule : clmul_16x4

// File: rtl/gf16_mult_seq.sv
// Sequential GF(2^16) multiplier, c = a*b mod (x^16 + POLY).
// b is consumed one nibble per cycle (MSB nibble first), Horner style:
// acc <= reduce((acc << 4) ^ clmul(a, nibble)). Latency 4 cycles from accept
// to out_valid; result held in DONE until the consumer takes it.
// Optional build macro GF16_MULT_RAW_EN adds c_raw, the unreduced 31-bit
// carryless product, built in parallel with the reduced one.
module gf16_mult_seq
    import gf16_pkg::*;
#(
    parameter logic [15:0] POLY = POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c
`ifdef GF16_MULT_RAW_EN
    ,
    output logic [30:0] c_raw
`endif
);

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;

    logic [15:0]      b_shift;
    logic [NIB_W-1:0] nibble;
    logic [18:0]      pp;
    logic [19:0]      t;
    logic [18:0]      fold;
    logic             fold_unused;
    logic [15:0]      acc_step;

    // Select the current nibble: step 0 -> b[15:12] ... step 3 -> b[3:0].
    assign b_shift = b_q >> {(2'd3 - step_q), 2'b00};
    assign nibble  = b_shift[NIB_W-1:0];

    clmul_16x4 u_clmul_pp (
        .a_i (a_q),
        .b_i (nibble),
        .p_o (pp)
    );

    assign t = {acc_q, 4'b0000} ^ {1'b0, pp};

    // Bits 19:16 of t stand for x^16..x^19; replace them by their residue
    // t[19:16]*POLY. With the default polynomial the fold fits in 9 bits.
    clmul_16x4 u_clmul_fold (
        .a_i (POLY),
        .b_i (t[19:16]),
        .p_o (fold)
    );

    assign acc_step    = t[15:0] ^ fold[15:0];
    assign fold_unused = ^fold[18:16];

`ifdef GF16_MULT_RAW_EN
    logic [30:0] raw_q, raw_d;
`endif

    // Next-state and handshake outputs; every target gets its hold value first.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        step_d    = step_q;
`ifdef GF16_MULT_RAW_EN
        raw_d     = raw_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = '0;
`ifdef GF16_MULT_RAW_EN
                    raw_d   = '0;
`endif
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d  = acc_step;
                step_d = step_q + 2'd1;
`ifdef GF16_MULT_RAW_EN
                raw_d  = {raw_q[26:0], 4'b0000} ^ {12'd0, pp};
`endif
                if (step_q == 2'(NIB_STEPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: captured operands, accumulator, step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign c = out_valid ? acc_q : 16'd0;

`ifdef GF16_MULT_RAW_EN
    // Unreduced carryless product, accumulated alongside acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

    assign c_raw = out_valid ? raw_q : 31'd0;
`endif

endmodule : gf16_mult_seq

// File: tb/tb_gf16_mult_seq.sv
// Directed and random checks for gf16_mult_seq (optionally with GF16_MULT_RAW_EN).
module tb_gf16_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
`ifdef GF16_MULT_RAW_EN
    logic [30:0] c_raw;
`endif

    int checks;
    int errors;

    gf16_mult_seq #(.POLY(16'h002B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
`ifdef GF16_MULT_RAW_EN
        ,
        .c_raw     (c_raw)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitwise shift-and-add reference: MSB of b first, reduce one bit at a time.
    function automatic logic [15:0] gf_ref(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 15; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ (r[15] ? 16'h002B : 16'h0000);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    // Present one operand pair, wait for acceptance, then scramble the inputs and
    // count edges until out_valid. Returns at a negedge with out_valid sampled.
    task automatic op(input logic [15:0] ai, input logic [15:0] bi,
                      output logic [15:0] cg, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        cg  = 16'd0;
        @(negedge clk);
        in_valid = 1'b1;
        a = ai;
        b = bi;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        ok = out_valid;
        cg = c;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 16'd0;
        b = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (c !== 16'h0000) begin
            errors++;
            $display("FAIL reset_c got %h want 0000", c);
        end
`ifdef GF16_MULT_RAW_EN
        checks++;
        if (c_raw !== 31'd0) begin
            errors++;
            $display("FAIL reset_c_raw got %h want 0", c_raw);
        end
`endif
        $display("reset: in_ready=%b out_valid=%b c=%h", in_ready, out_valid, c);
    endtask

    task automatic test_identity_latency();
        logic [15:0] cg;
        int lat;
        bit ok;
        op(16'h0001, 16'h1234, cg, lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL identity_timeout out_valid never rose");
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL identity_latency got %0d want 4", lat);
        end
        checks++;
        if (cg !== 16'h1234) begin
            errors++;
            $display("FAIL identity_c got %h want 1234", cg);
        end
        $display("op a=0001 b=1234 c=%h latency=%0d", cg, lat);
        consume();
    endtask

    task automatic test_vectors();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [15:0] vc [5];
        logic [15:0] cg;
        int lat;
        bit ok;
        va = '{16'h8000, 16'hFFFF, 16'h0100, 16'h0003, 16'h8000};
        vb = '{16'h0002, 16'h0000, 16'h0100, 16'h0003, 16'h8000};
        vc = '{16'h002B, 16'h0000, 16'h002B, 16'h0005, 16'hC10E};
        for (int i = 0; i < 5; i++) begin
            op(va[i], vb[i], cg, lat, ok);
            checks++;
            if (!ok || cg !== vc[i]) begin
                errors++;
                $display("FAIL vector_%0d got %h (valid %b) want %h", i, cg, ok, vc[i]);
            end
`ifdef GF16_MULT_RAW_EN
            if (i == 0) begin
                checks++;
                if (c_raw !== 31'h0001_0000) begin
                    errors++;
                    $display("FAIL vector_c_raw got %h want 0010000", c_raw);
                end
            end
`endif
            $display("op a=%h b=%h c=%h latency=%0d", va[i], vb[i], cg, lat);
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] cg;
        int lat;
        bit ok;
        op(16'h0003, 16'h0003, cg, lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout out_valid never rose");
        end
        in_valid = 1'b1;
        a = 16'hDEAD;
        b = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || c !== 16'h0005 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b c=%h in_ready=%b want 1 0005 0",
                         i, out_valid, c, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        $display("backpressure: held 10 cycles, c=%h", cg);
    endtask

    task automatic test_reset_mid_mul();
        logic [15:0] cg;
        int lat;
        bit ok;
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || c !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs got valid=%b c=%h want 0 0000", out_valid, c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        op(16'h8000, 16'h8000, cg, lat, ok);
        checks++;
        if (!ok || cg !== 16'hC10E || lat != 4) begin
            errors++;
            $display("FAIL midreset_next got %h lat %0d want c10e lat 4", cg, lat);
        end
        $display("reset mid-MUL then op a=8000 b=8000 c=%h", cg);
        consume();
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, exp_c, cg;
        int lat;
        bit ok;
        bit taken;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 97 == 0) ra = 16'h0000;
            if (i % 89 == 0) rb = 16'h0000;
            exp_c = gf_ref(ra, rb);
            op(ra, rb, cg, lat, ok);
            taken = 1'b0;
            for (int k = 0; k < 40 && !taken; k++) begin
                checks++;
                if (out_valid !== 1'b1 || c !== exp_c) begin
                    errors++;
                    $display("FAIL random_%0d a=%h b=%h got %h (valid %b) want %h",
                             i, ra, rb, c, out_valid, exp_c);
                end
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                if (out_ready) taken = 1'b1;
                else @(negedge clk);
            end
            out_ready = 1'b0;
            if (!taken) begin
                checks++;
                errors++;
                $display("FAIL random_%0d handshake never completed", i);
            end
            $display("rand %0d a=%h b=%h c=%h exp=%h", i, ra, rb, cg, exp_c);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_identity_latency();
        test_vectors();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gf16_mult_seq
